// File: rtl/reg_resp_fifo.sv
// Divider result buffer: DEPTH-entry FIFO of {quotient, remainder} pairs with
// registered head outputs that hold the last presented result once drained.
module reg_resp_fifo #(
  parameter  int QW    = 8,
  parameter  int RW    = 9,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fim_div,
  input  logic [QW-1:0] quoc,
  input  logic [RW-1:0] rest,
  input  logic          le,
  input  logic          limpa,
  output logic [QW-1:0] quocienteFim,
  output logic [RW-1:0] restoFim,
  output logic          valido,
  output logic          cheio,
  output logic          vazio,
  output logic [CW-1:0] ocupacao,
  output logic          estouro
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [QW-1:0] q;
    logic [RW-1:0] r;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          din;
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0]   occ;
  logic            pop, push;

  generate
    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
      $error("reg_resp_fifo: DEPTH must be a power of two >= 2");
    end
  endgenerate

  assign din    = '{q: quoc, r: rest};
  assign rd_nxt = rd_ptr + AW'(1);

  assign valido   = (occ != '0);
  assign vazio    = (occ == '0);
  assign cheio    = (occ == CW'(DEPTH));
  assign ocupacao = occ;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign pop  = le & valido;
  assign push = fim_div & (~cheio | pop);

  // Storage is not reset; only pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (!limpa && push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      estouro      <= 1'b0;
      quocienteFim <= '0;
      restoFim     <= '0;
    end else if (limpa) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      estouro <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_nxt;
      if (push && !pop)      occ <= occ + CW'(1);
      else if (pop && !push) occ <= occ - CW'(1);
      if (fim_div && cheio && !pop) estouro <= 1'b1;
      // Head bypass when the pushed entry becomes the new head, else read ahead.
      if (push && (vazio || (pop && occ == CW'(1)))) begin
        quocienteFim <= din.q;
        restoFim     <= din.r;
      end else if (pop && occ > CW'(1)) begin
        quocienteFim <= mem[rd_nxt].q;
        restoFim     <= mem[rd_nxt].r;
      end
    end
  end

endmodule

// File: doc/reg_resp_fifo.md
# reg_resp_fifo

Parametrised result buffer for the divider datapath. Captures a quotient/remainder pair on every `fim_div` pulse into a DEPTH-entry FIFO. Presents the oldest pair on registered outputs with a valid/read handshake, so back-to-back divisions are not lost while the consumer is busy. Sits between the divider core and the result consumer, replacing the single-entry result register.

## Interface

Parameters:
- `QW`, default 8: quotient width.
- `RW`, default 9: remainder width.
- `DEPTH`, default 4: number of entries; power of two, ≥ 2.
- `CW`: derived, $clog2(DEPTH)+1; occupancy counter width.

Ports:
- `clk`, in, 1: single clock; all state changes on rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `fim_div`, in, 1: divider-done strobe; push request for `quoc`/`rest`.
- `quoc`, in, QW: quotient to capture.
- `rest`, in, RW: remainder to capture.
- `le`, in, 1: consumer read; pops the head entry when `valido`=1.
- `limpa`, in, 1: synchronous flush; also clears `estouro`.
- `quocienteFim`, out, QW: head-entry quotient (registered).
- `restoFim`, out, RW: head-entry remainder (registered).
- `valido`, out, 1: head outputs hold an unread entry.
- `cheio`, out, 1: occupancy == DEPTH.
- `vazio`, out, 1: occupancy == 0.
- `ocupacao`, out, CW: number of stored unread entries, 0..DEPTH.
- `estouro`, out, 1: sticky; a push was dropped because the FIFO was full.

## Operation

- Storage: circular array of DEPTH {quoc, rest} entries.
  - Write pointer and read pointer, each $clog2(DEPTH) bits, wrap naturally modulo DEPTH.
  - Occupancy counter width CW.
- Push accepted when `fim_div`=1 and (not `cheio`, or a pop occurs in the same cycle).
  - Accepted push writes {quoc, rest} at the write pointer and increments it.
- Pop occurs when `le`=1 and `valido`=1; increments the read pointer. `le` while `vazio` is ignored.
- Occupancy update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Full with push and pop in the same cycle: push accepted, no overflow.
- Full with push and no pop: push dropped, storage and pointers unchanged, `estouro` set to 1.
- `estouro` stays set until `rst` or `limpa`.
- Empty with push and `le` in the same cycle: push accepted, pop ignored; occupancy becomes 1.
- Head outputs (`quocienteFim`/`restoFim`):
  - Registered; after every edge they equal the entry at the new read pointer whenever the new occupancy > 0.
  - When the FIFO goes empty, they hold the last value presented.
  - This preserves the old hold-last-result behaviour for consumers that ignore `valido`.
  - Push into empty FIFO: outputs load the pushed data directly (bypass) in the same edge.
- Flags:
  - `valido` = (occupancy > 0).
  - `cheio` and `vazio` are decoded from the occupancy register, so they are glitch-free registered-state functions.
- `limpa`=1: on the next edge pointers and occupancy go to 0 and `estouro` goes to 0.
  - Head outputs keep their value.
  - A simultaneous `fim_div` is discarded; `limpa` has priority over push and pop.
- Reset (`rst`=1, asynchronous): pointers, occupancy, `estouro`, `quocienteFim`, `restoFim` all cleared to 0.
  - `vazio`=1, `valido`=0, `cheio`=0.
  - Array contents need not be cleared.
  - Reset mid-operation discards all entries immediately, without waiting for a clock edge.

## Timing

- Push latency: `fim_div` sampled at edge N; data visible on `quocienteFim`/`restoFim` with `valido`=1 after edge N if the FIFO was empty.
  - Otherwise the data becomes visible after the pop that exposes it.
- Pop: `le` sampled at edge N; next entry (or held value with `valido`=0) presented after edge N.
- Sustained throughput: one push and one pop per cycle.
- `ocupacao`, `cheio`, `vazio`, and `estouro` all update at the same edge as the pointers.
- No combinational path from inputs to outputs.
- `rst` release: first active edge is the first edge after `rst` falls.

## Test plan

- Reset, then single push `quoc`=8'h2A, `rest`=9'h005 -> after edge: `quocienteFim`=8'h2A, `restoFim`=9'h005, `valido`=1, `ocupacao`=1. Then `le`=1 for one cycle -> `valido`=0, `vazio`=1, outputs stay 8'h2A/9'h005.
- Push 1,2,3,4 (DEPTH=4) with `le`=0 -> `cheio`=1, `ocupacao`=4, head=1. Push 5 -> dropped, `estouro`=1. Pop ×4 -> read order 1,2,3,4, then `vazio`=1.
- Full FIFO, push 9 and `le`=1 together -> no overflow, `ocupacao` stays 4, tail entry is 9, head advances to 2.
- Empty FIFO, `fim_div` and `le` together with quoc=7 -> `ocupacao`=1, head=7, `valido`=1.
- Wrap-around: 10 cycles of alternating push/pop with incrementing data -> every pop returns data in push order, and pointers wrap past DEPTH−1 cleanly.
- With 3 entries and `estouro`=1:
  - Assert `limpa` with `fim_div` -> `ocupacao`=0, `estouro`=0, head outputs unchanged.
  - Repeat with `rst` pulsed between edges -> outputs go to 0 immediately.
